// File: rtl/enemy_tile_arbiter.sv
// enemy_tile_arbiter: round-robin sharing of one background tile-lookup port among N enemy movers.
module enemy_tile_arbiter #(
  parameter int N = 4,
  parameter int ROWS = 12,
  parameter int COLS = 17,
  parameter logic [7:0] BDR = 8'd0
) (
  input  logic                movement_clock_i,
  input  logic                reset_i,
  input  logic [N-1:0]        req_i,
  input  logic [N-1:0][3:0]   req_row_i,
  input  logic [N-1:0][4:0]   req_col_i,
  output logic [3:0]          bg_row_o,
  output logic [4:0]          bg_col_o,
  input  logic [7:0]          bg_tile_i,
  output logic [N-1:0]        gnt_o,
  output logic [N-1:0]        rsp_valid_o,
  output logic [7:0]          rsp_tile_o,
  output logic                busy_o
);
  localparam int PW = $clog2(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  logic [PW-1:0] ptr_q, ptr_d, s2_idx_q, win_idx;
  logic          s2_valid_q, s2_oor_q, win_found, win_oor;
  logic [N-1:0]  gnt_q, rsp_valid_q, inflight_mask, eligible;
  logic [7:0]    rsp_tile_q;
  logic [3:0]    bg_row_q;
  logic [4:0]    bg_col_q;
  assign inflight_mask = s2_valid_q ? (ONE << s2_idx_q) : '0;
  assign eligible = req_i & ~inflight_mask;
  // First eligible index starting at ptr, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!win_found && eligible[j]) begin
        win_found = 1'b1;
        win_idx = PW'(j);
      end
    end
  end
  assign win_oor = (32'(req_row_i[win_idx]) >= ROWS) || (32'(req_col_i[win_idx]) >= COLS);
  assign ptr_d = (32'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
  always_ff @(posedge movement_clock_i) begin
    if (reset_i) begin
      ptr_q <= '0;
      s2_valid_q <= 1'b0;
      s2_idx_q <= '0;
      s2_oor_q <= 1'b0;
      gnt_q <= '0;
      rsp_valid_q <= '0;
      rsp_tile_q <= BDR;
      bg_row_q <= '0;
      bg_col_q <= '0;
    end else begin
      gnt_q <= win_found ? (ONE << win_idx) : '0;
      s2_valid_q <= win_found;
      rsp_valid_q <= inflight_mask;
      if (s2_valid_q) rsp_tile_q <= s2_oor_q ? BDR : bg_tile_i;
      if (win_found) begin
        ptr_q <= ptr_d;
        s2_idx_q <= win_idx;
        s2_oor_q <= win_oor;
        bg_row_q <= req_row_i[win_idx];
        bg_col_q <= req_col_i[win_idx];
      end
    end
  end
  assign gnt_o = gnt_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_tile_o = rsp_tile_q;
  assign bg_row_o = bg_row_q;
  assign bg_col_o = bg_col_q;
  assign busy_o = s2_valid_q;
endmodule

// File: tb/tb_enemy_tile_arbiter.sv
// tb_enemy_tile_arbiter: directed checks of grant order, response data, masking and reset.
module tb_enemy_tile_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req;
  logic [N-1:0][3:0] req_row;
  logic [N-1:0][4:0] req_col;
  logic [3:0] bg_row;
  logic [4:0] bg_col;
  logic [7:0] bg_tile;
  logic [N-1:0] gnt, rsp_valid;
  logic [7:0] rsp_tile;
  logic busy;
  logic [7:0] bg [12][17];
  int n_chk = 0, n_fail = 0;

  enemy_tile_arbiter #(.N(N)) dut (
    .movement_clock_i(clk), .reset_i(rst), .req_i(req), .req_row_i(req_row),
    .req_col_i(req_col), .bg_row_o(bg_row), .bg_col_o(bg_col), .bg_tile_i(bg_tile),
    .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_tile_o(rsp_tile), .busy_o(busy)
  );

  always #5 clk = ~clk;
  // Out-of-range addresses present a distinctive junk value the arbiter must ignore.
  assign bg_tile = (bg_row < 4'd12 && bg_col < 5'd17) ? bg[bg_row][bg_col] : 8'hAA;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [N-1:0] exp_g [5];
    int grants;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 17; c++) bg[r][c] = 8'(r * 17 + c + 1);
    bg[3][5] = 8'd2;
    rst = 1'b1; req = '0; req_row = '0; req_col = '0;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk("rst_tile", 32'(rsp_tile), 0);
    chk("rst_row", 32'(bg_row), 0);
    chk("rst_col", 32'(bg_col), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    // single request
    req = 4'b0001; req_row[0] = 4'd3; req_col[0] = 5'd5;
    tick();
    chk("s_gnt", 32'(gnt), 32'b0001);
    chk("s_row", 32'(bg_row), 3);
    chk("s_col", 32'(bg_col), 5);
    chk("s_busy1", 32'(busy), 1);
    chk("s_rsp0", 32'(rsp_valid), 0);
    tick();
    chk("s_gnt_masked", 32'(gnt), 0);
    chk("s_rsp", 32'(rsp_valid), 32'b0001);
    chk("s_tile", 32'(rsp_tile), 2);
    chk("s_busy0", 32'(busy), 0);
    req = '0;
    tick();
    chk("s_rsp_pulse", 32'(rsp_valid), 0);
    chk("s_tile_hold", 32'(rsp_tile), 2);
    // round robin from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) begin req_row[i] = 4'(i); req_col[i] = 5'(i); end
    req = 4'b1111;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(exp_g[k]));
      if (k > 0) begin
        chk($sformatf("rr_rsp%0d", k), 32'(rsp_valid), 32'(exp_g[k-1]));
        chk($sformatf("rr_tile%0d", k), 32'(rsp_tile), 32'(bg[k-1][k-1]));
      end
    end
    req = '0;
    tick();
    chk("rr_gnt_end", 32'(gnt), 0);
    chk("rr_rsp_end", 32'(rsp_valid), 32'b0001);
    tick();
    // out of range row, then column (pointer now 1)
    req = 4'b0100; req_row[2] = 4'd12; req_col[2] = 5'd3;
    tick();
    chk("oor_gnt", 32'(gnt), 32'b0100);
    tick();
    chk("oor_rsp", 32'(rsp_valid), 32'b0100);
    chk("oor_tile_row", 32'(rsp_tile), 0);
    req_row[2] = 4'd0; req_col[2] = 5'd17;
    tick();
    chk("oor_gnt2", 32'(gnt), 32'b0100);
    tick();
    chk("oor_rsp2", 32'(rsp_valid), 32'b0100);
    chk("oor_tile_col", 32'(rsp_tile), 0);
    req = '0;
    tick();
    // lone requester masked while in flight
    req = 4'b0100; req_row[2] = 4'd1; req_col[2] = 5'd2;
    grants = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("mask_gnt%0d", k), 32'(gnt), (k % 2 == 0) ? 32'b0100 : 0);
      if (gnt[2]) grants++;
    end
    chk("mask_count", 32'(grants), 3);
    chk("mask_last_rsp", 32'(rsp_valid), 32'b0100);
    chk("mask_tile", 32'(rsp_tile), 32'(bg[1][2]));
    req = '0;
    tick();
    // late drop with address change after grant (pointer now 3)
    req = 4'b0010; req_row[1] = 4'd2; req_col[1] = 5'd4;
    tick();
    chk("ld_gnt", 32'(gnt), 32'b0010);
    req = '0; req_row[1] = 4'd7;
    tick();
    chk("ld_rsp", 32'(rsp_valid), 32'b0010);
    chk("ld_tile", 32'(rsp_tile), 32'(bg[2][4]));
    // reset mid-operation
    req = 4'b0010; req_row[1] = 4'd1; req_col[1] = 5'd1;
    tick();
    chk("rm_gnt", 32'(gnt), 32'b0010);
    rst = 1'b1; req = '0;
    tick();
    chk("rm_gnt0", 32'(gnt), 0);
    chk("rm_rsp0", 32'(rsp_valid), 0);
    chk("rm_tile", 32'(rsp_tile), 0);
    chk("rm_row", 32'(bg_row), 0);
    chk("rm_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();
    chk("rm_no_rsp", 32'(rsp_valid), 0);
    req = 4'b1010; req_row[3] = 4'd4; req_col[3] = 5'd6;
    tick();
    chk("rm_first_gnt", 32'(gnt), 32'b0010);
    tick();
    chk("rm_second_gnt", 32'(gnt), 32'b1000);
    chk("rm_overlap_rsp", 32'(rsp_valid), 32'b0010);
    chk("rm_overlap_tile", 32'(rsp_tile), 32'(bg[1][1]));
    req = '0;
    tick();
    chk("rm_last_rsp", 32'(rsp_valid), 32'b1000);
    chk("rm_last_tile", 32'(rsp_tile), 32'(bg[4][6]));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
